// File: rtl/lfsr4_pkg.sv
// lfsr4_pkg
//   Shared definitions for the 4-bit Galois LFSR generator and its checker.
//   Both sides call lfsr4_next so they can never disagree on the sequence.
//   Contents:
//     LFSR4_SEED     generator reset word (the sequence wraps through it, period 15)
//     lfsr4_state_e  checker FSM state (HUNT / LOCKED)
//     lfsr4_next()   next-state function of the 4-bit Galois LFSR
package lfsr4_pkg;

  localparam logic [3:0] LFSR4_SEED = 4'b1000;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lfsr4_state_e;

  // Sequence from the seed: 8,4,2,1,C,6,3,D,A,5,E,7,F,B,9,8,...
  function automatic logic [3:0] lfsr4_next(input logic [3:0] s);
    return {s[0], s[3] ^ s[0], s[2], s[1]};
  endfunction

endpackage

// File: rtl/lfsr4_seq_checker.sv
// lfsr4_seq_checker
//   Pass/fail monitor for a 4-bit Galois LFSR stream. Samples the generator
//   word on every valid cycle, predicts the next word, synchronises after a
//   run of correct predictions, then flags and counts sequence errors while
//   locked. Also detects the illegal all-zero lock-up word.
//
//   Handshake: in_valid qualifies in_state for exactly one cycle; there is no
//   back-pressure (the checker accepts every valid sample). With in_valid=0
//   nothing changes and both pulses are 0.
//
//   Ports:
//     clk, rst     clock (rising edge), asynchronous active-high reset
//     in_valid     in_state carries a new generator sample this cycle
//     in_state     generator state word
//     clr_cnt      synchronous clear of err_count and zero_seen
//     locked       checker synchronised to the sequence
//     err_pulse    one-cycle pulse: mismatch while locked
//     wrap_pulse   one-cycle pulse: matched SEED word while locked
//     zero_seen    sticky: an all-zero word was sampled
//     err_count    saturating count of mismatches while locked
//     dbg_state    current FSM state, for debug / assertion binding
//   All outputs are registered: they reflect the sample taken at the previous
//   rising edge.
module lfsr4_seq_checker
  import lfsr4_pkg::*;
#(
  parameter logic [3:0] SEED         = LFSR4_SEED,
  parameter int          SYNC_MATCHES = 4,
  parameter int          LOSS_ERRORS  = 3,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_state,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic             zero_seen,
  output logic [CNT_W-1:0] err_count,
  output lfsr4_state_e     dbg_state
);

  localparam logic [3:0] SYNC_TGT = 4'(SYNC_MATCHES);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_ERRORS);

  lfsr4_state_e     state_q, state_d;
  logic [3:0]       prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             zero_seen_q, zero_seen_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic [3:0] pred;
  logic       match;

  // The zero word is the LFSR lock-up state and can never be a legal
  // successor, so it is rejected even if prev were somehow zero.
  assign pred  = lfsr4_next(prev_q);
  assign match = have_prev_q && (in_state == pred) && (in_state != 4'd0);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    have_prev_d  = have_prev_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    zero_seen_d  = zero_seen_q;
    err_count_d  = err_count_q;

    if (in_valid) begin
      if (in_state == 4'd0) begin
        zero_seen_d = 1'b1;
      end

      case (state_q)
        HUNT: begin
          // While hunting, always re-anchor on the latest sample.
          prev_d      = in_state;
          have_prev_d = 1'b1;
          if (match) begin
            if (match_cnt_q + 4'd1 == SYNC_TGT) begin
              state_d     = LOCKED;
              match_cnt_d = 4'd0;
            end else begin
              match_cnt_d = match_cnt_q + 4'd1;
            end
          end else begin
            match_cnt_d = 4'd0;
          end
        end

        LOCKED: begin
          if (match) begin
            prev_d     = in_state;
            miss_cnt_d = 4'd0;
            if (in_state == SEED) begin
              wrap_pulse_d = 1'b1;
            end
          end else begin
            // Flywheel: advance on the prediction rather than the bad word,
            // so a single corrupted word costs one error, not two.
            prev_d      = pred;
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
            if (miss_cnt_q + 4'd1 == LOSS_TGT) begin
              state_d     = HUNT;
              have_prev_d = 1'b0;
              miss_cnt_d  = 4'd0;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end

    // Clear has priority over a same-cycle increment or sticky set.
    if (clr_cnt) begin
      err_count_d = '0;
      zero_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      prev_q       <= 4'd0;
      have_prev_q  <= 1'b0;
      match_cnt_q  <= 4'd0;
      miss_cnt_q   <= 4'd0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      zero_seen_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      have_prev_q  <= have_prev_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      zero_seen_q  <= zero_seen_d;
      err_count_q  <= err_count_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign zero_seen  = zero_seen_q;
  assign err_count  = err_count_q;
  assign dbg_state  = state_q;

endmodule
